hv_stream_unpack: RTL and testbench

//  Receive side of the 32-bit result stream: assembles WORDS consecutive 32-bit beats into one
//  (DIM+1)-bit hypervector and presents it to the cores with a valid/ready handshake.

---
 rtl/hv_stream_unpack.sv | 100 ++++++++++
 tb/tb_hv_stream_unpack.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hv_stream_unpack.sv
// Receive side of the 32-bit result stream. Assembles WORDS beats into one (DIM+1)-bit
// hypervector in an assembly register, then moves it to an output register with valid/ready.
module hv_stream_unpack #(
  parameter int DIM   = 1023,
  parameter int WORDS = (DIM + 1) / 32,
  parameter int CNT_W = 26
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             src_v_i,
  input  logic [31:0]      src_d_i,
  output logic             src_ready_o,
  output logic             hv_v_o,
  input  logic             hv_ready_i,
  output logic [DIM:0]     hv_d_o,
  output logic [4:0]       word_idx_o,
  output logic [CNT_W-1:0] hv_cnt_o
);

  localparam logic [4:0] LAST_IDX = 5'(WORDS - 1);

  logic [DIM:0]     asm_q, asm_d;
  logic             asm_full_q, asm_full_d;
  logic [4:0]       word_idx_q, word_idx_d;
  logic [DIM:0]     hv_d_q, hv_d_d;
  logic             hv_v_q, hv_v_d;
  logic [CNT_W-1:0] hv_cnt_q, hv_cnt_d;

  logic accept;
  logic transfer;
  logic consume;

  // Accept and transfer are mutually exclusive because accept needs an empty assembly stage.
  assign accept   = src_v_i && !asm_full_q;
  assign transfer = asm_full_q && (!hv_v_q || hv_ready_i);
  assign consume  = hv_v_q && hv_ready_i;

  always_comb begin
    asm_d      = asm_q;
    asm_full_d = asm_full_q;
    word_idx_d = word_idx_q;
    hv_d_d     = hv_d_q;
    hv_v_d     = hv_v_q;
    hv_cnt_d   = hv_cnt_q;

    if (accept) begin
      asm_d[{word_idx_q, 5'b00000} +: 32] = src_d_i;
      if (word_idx_q == LAST_IDX) begin
        word_idx_d = 5'd0;
        asm_full_d = 1'b1;
      end else begin
        word_idx_d = word_idx_q + 5'd1;
      end
    end

    if (transfer) begin
      hv_d_d     = asm_q;
      hv_v_d     = 1'b1;
      asm_full_d = 1'b0;
    end else if (consume) begin
      hv_v_d = 1'b0;
    end

    if (consume) begin
      hv_cnt_d = hv_cnt_q + 1'b1;
    end
  end

  // Flush keeps the data registers; only control state and the delivery count are cleared.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      asm_q      <= '0;
      asm_full_q <= 1'b0;
      word_idx_q <= 5'd0;
      hv_d_q     <= '0;
      hv_v_q     <= 1'b0;
      hv_cnt_q   <= '0;
    end else if (flush_i) begin
      asm_full_q <= 1'b0;
      word_idx_q <= 5'd0;
      hv_v_q     <= 1'b0;
      hv_cnt_q   <= '0;
    end else begin
      asm_q      <= asm_d;
      asm_full_q <= asm_full_d;
      word_idx_q <= word_idx_d;
      hv_d_q     <= hv_d_d;
      hv_v_q     <= hv_v_d;
      hv_cnt_q   <= hv_cnt_d;
    end
  end

  assign src_ready_o = !asm_full_q;
  assign hv_v_o      = hv_v_q;
  assign hv_d_o      = hv_d_q;
  assign word_idx_o  = word_idx_q;
  assign hv_cnt_o    = hv_cnt_q;

endmodule

// File: tb/tb_hv_stream_unpack.sv
// Directed and randomized checks of hv_stream_unpack: assembly order, buffering,
// back-to-back throughput, flush, reset, and in-order delivery against a scoreboard.
module tb_hv_stream_unpack;

  localparam int DIM   = 1023;
  localparam int WORDS = 32;
  localparam int CNT_W = 26;

  logic             clk = 1'b0;
  logic             rst;
  logic             flush;
  logic             srcV;
  logic [31:0]      srcD;
  logic             srcReady;
  logic             hvV;
  logic             hvReady;
  logic [DIM:0]     hvD;
  logic [4:0]       wordIdx;
  logic [CNT_W-1:0] hvCnt;

  int nApplied = 0;
  int nMiss    = 0;

  hv_stream_unpack #(.DIM(DIM), .WORDS(WORDS), .CNT_W(CNT_W)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .flush_i    (flush),
    .src_v_i    (srcV),
    .src_d_i    (srcD),
    .src_ready_o(srcReady),
    .hv_v_o     (hvV),
    .hv_ready_i (hvReady),
    .hv_d_o     (hvD),
    .word_idx_o (wordIdx),
    .hv_cnt_o   (hvCnt)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Presents one beat, waits (bounded) for the block to be ready, and lets it be accepted.
  task automatic applyStimulus(input logic [31:0] d);
    int guard;
    srcV  = 1'b1;
    srcD  = d;
    guard = 0;
    while (!srcReady && guard < 200) begin
      step();
      guard++;
    end
    nApplied++;
    if (guard >= 200) begin
      nMiss++;
      $display("[TB] FAIL beat_timeout: src_ready stayed %b, wanted 1", srcReady);
    end
    step();
    srcV = 1'b0;
  endtask

  task automatic pulse_reset();
    srcV  = 1'b0;
    flush = 1'b0;
    rst   = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    hvReady = 1'b0;
    srcD    = 32'h0;
    pulse_reset();
    nApplied++;
    if (hvV !== 1'b0) begin nMiss++; $display("[TB] FAIL reset_hv_v: got %b want 0", hvV); end
    nApplied++;
    if (hvD !== '0) begin nMiss++; $display("[TB] FAIL reset_hv_d: got %h want 0", hvD); end
    nApplied++;
    if (wordIdx !== 5'd0) begin nMiss++; $display("[TB] FAIL reset_word_idx: got %0d want 0", wordIdx); end
    nApplied++;
    if (hvCnt !== '0) begin nMiss++; $display("[TB] FAIL reset_hv_cnt: got %0d want 0", hvCnt); end
    nApplied++;
    if (srcReady !== 1'b1) begin nMiss++; $display("[TB] FAIL reset_src_ready: got %b want 1", srcReady); end
  endtask

  task automatic test_assembly_order();
    logic [DIM:0]  expV;
    logic [31:0]   w;
    hvReady = 1'b1;
    for (int k = 0; k < WORDS; k++) begin
      w = k * 32'h01010101;
      expV[32*k +: 32] = w;
      applyStimulus(w);
    end
    nApplied++;
    if (srcReady !== 1'b0 || hvV !== 1'b0) begin
      nMiss++; $display("[TB] FAIL asm_full_bubble: src_ready=%b hv_v=%b want 0/0", srcReady, hvV);
    end
    step();
    nApplied++;
    if (hvV !== 1'b1) begin nMiss++; $display("[TB] FAIL order_hv_v: got %b want 1", hvV); end
    nApplied++;
    if (hvD !== expV) begin nMiss++; $display("[TB] FAIL order_hv_d: got %h want %h", hvD, expV); end
    nApplied++;
    if (srcReady !== 1'b1) begin nMiss++; $display("[TB] FAIL order_src_ready: got %b want 1", srcReady); end
    step();
    nApplied++;
    if (hvCnt !== 26'd1 || hvV !== 1'b0) begin
      nMiss++; $display("[TB] FAIL order_hv_cnt: got cnt=%0d v=%b want 1/0", hvCnt, hvV);
    end
  endtask

  task automatic test_double_buffer();
    logic [DIM:0] vecA, vecB;
    pulse_reset();
    hvReady = 1'b0;
    for (int k = 0; k < WORDS; k++) begin
      vecA[32*k +: 32] = 32'hA000_0000 | k;
      applyStimulus(32'hA000_0000 | k);
    end
    for (int k = 0; k < WORDS; k++) begin
      vecB[32*k +: 32] = 32'hB000_0000 | k;
      applyStimulus(32'hB000_0000 | k);
    end
    // Extra beats offered while both stages are full must be ignored.
    srcV = 1'b1;
    srcD = 32'hDEAD_BEEF;
    for (int c = 0; c < 4; c++) step();
    nApplied++;
    if (srcReady !== 1'b0) begin nMiss++; $display("[TB] FAIL stall_src_ready: got %b want 0", srcReady); end
    nApplied++;
    if (hvV !== 1'b1 || hvD !== vecA) begin
      nMiss++; $display("[TB] FAIL stall_hold_A: v=%b got %h want %h", hvV, hvD, vecA);
    end
    nApplied++;
    if (wordIdx !== 5'd0) begin nMiss++; $display("[TB] FAIL stall_word_idx: got %0d want 0", wordIdx); end
    srcV    = 1'b0;
    hvReady = 1'b1;
    step();
    nApplied++;
    if (hvV !== 1'b1 || hvD !== vecB || hvCnt !== 26'd1) begin
      nMiss++; $display("[TB] FAIL swap_to_B: v=%b cnt=%0d got %h want %h", hvV, hvCnt, hvD, vecB);
    end
    nApplied++;
    if (srcReady !== 1'b1) begin nMiss++; $display("[TB] FAIL swap_src_ready: got %b want 1", srcReady); end
    step();
    nApplied++;
    if (hvV !== 1'b0 || hvCnt !== 26'd2) begin
      nMiss++; $display("[TB] FAIL drain_B: v=%b cnt=%0d want 0/2", hvV, hvCnt);
    end
  endtask

  task automatic test_back_to_back();
    logic [DIM:0] expV [3];
    int beat, cycles, seen, stalls;
    pulse_reset();
    for (int v = 0; v < 3; v++)
      for (int k = 0; k < WORDS; k++)
        expV[v][32*k +: 32] = 32'h0100_0000 * (v + 1) + k;
    hvReady = 1'b1;
    beat = 0; cycles = 0; seen = 0; stalls = 0;
    while (seen < 3 && cycles < 300) begin
      srcV = (beat < 3 * WORDS);
      srcD = (beat < 3 * WORDS) ? expV[beat / WORDS][32*(beat % WORDS) +: 32] : 32'h0;
      if (!srcReady) stalls++;
      if (srcV && srcReady) beat++;
      step();
      cycles++;
      if (hvV) begin
        nApplied++;
        if (hvD !== expV[seen]) begin
          nMiss++; $display("[TB] FAIL b2b_vec%0d: got %h want %h", seen, hvD, expV[seen]);
        end
        seen++;
      end
    end
    srcV = 1'b0;
    nApplied++;
    if (cycles !== 99) begin nMiss++; $display("[TB] FAIL b2b_cycles: got %0d want 99", cycles); end
    nApplied++;
    if (stalls !== 3) begin nMiss++; $display("[TB] FAIL b2b_stalls: got %0d want 3", stalls); end
    step();
    nApplied++;
    if (hvCnt !== 26'd3) begin nMiss++; $display("[TB] FAIL b2b_hv_cnt: got %0d want 3", hvCnt); end
  endtask

  task automatic test_flush();
    hvReady = 1'b1;
    for (int k = 0; k < 10; k++) applyStimulus(32'h5555_0000 | k);
    nApplied++;
    if (wordIdx !== 5'd10) begin nMiss++; $display("[TB] FAIL pre_flush_idx: got %0d want 10", wordIdx); end
    flush = 1'b1;
    srcV  = 1'b1;
    srcD  = 32'h1234_5678;
    step();
    flush = 1'b0;
    srcV  = 1'b0;
    nApplied++;
    if (wordIdx !== 5'd0 || hvCnt !== '0 || hvV !== 1'b0) begin
      nMiss++; $display("[TB] FAIL flush_state: idx=%0d cnt=%0d v=%b want 0/0/0", wordIdx, hvCnt, hvV);
    end
    for (int k = 0; k < WORDS; k++) applyStimulus(32'hFFFF_FFFF);
    step();
    nApplied++;
    if (hvV !== 1'b1 || hvD !== {(DIM+1){1'b1}} || wordIdx !== 5'd0) begin
      nMiss++; $display("[TB] FAIL flush_ones: v=%b idx=%0d got %h", hvV, wordIdx, hvD);
    end
    step();
    nApplied++;
    if (hvCnt !== 26'd1) begin nMiss++; $display("[TB] FAIL flush_hv_cnt: got %0d want 1", hvCnt); end
  endtask

  task automatic test_reset_midvector();
    hvReady = 1'b0;
    for (int k = 0; k < WORDS; k++) applyStimulus(32'hC000_0000 | k);
    step();
    for (int k = 0; k < 7; k++) applyStimulus(32'hD000_0000 | k);
    nApplied++;
    if (hvV !== 1'b1 || wordIdx !== 5'd7) begin
      nMiss++; $display("[TB] FAIL pre_rst: v=%b idx=%0d want 1/7", hvV, wordIdx);
    end
    pulse_reset();
    nApplied++;
    if (hvV !== 1'b0 || hvD !== '0 || wordIdx !== 5'd0 || srcReady !== 1'b1) begin
      nMiss++; $display("[TB] FAIL mid_rst: v=%b idx=%0d rdy=%b got %h", hvV, wordIdx, srcReady, hvD);
    end
  endtask

  task automatic test_random_scoreboard();
    logic [DIM:0] expV [50];
    logic [DIM:0] snap;
    int beat, got, cycles;
    logic hold;
    pulse_reset();
    for (int v = 0; v < 50; v++)
      for (int k = 0; k < WORDS; k++)
        expV[v][32*k +: 32] = $urandom;
    beat = 0; got = 0; cycles = 0;
    while (got < 50 && cycles < 20000) begin
      srcV    = (beat < 50 * WORDS) && ($urandom_range(0, 3) != 0);
      srcD    = (beat < 50 * WORDS) ? expV[beat / WORDS][32*(beat % WORDS) +: 32] : 32'h0;
      hvReady = ($urandom_range(0, 2) != 0);
      hold    = hvV && !hvReady;
      snap    = hvD;
      if (srcV && srcReady) beat++;
      if (hvV && hvReady) begin
        nApplied++;
        if (hvD !== expV[got]) begin
          nMiss++; $display("[TB] FAIL rand_vec%0d: got %h want %h", got, hvD, expV[got]);
        end
        got++;
      end
      step();
      cycles++;
      if (hold && (hvV !== 1'b1 || hvD !== snap)) begin
        nApplied++;
        nMiss++;
        $display("[TB] FAIL rand_hold: v=%b got %h want %h", hvV, hvD, snap);
      end
    end
    srcV    = 1'b0;
    hvReady = 1'b0;
    nApplied++;
    if (got !== 50) begin nMiss++; $display("[TB] FAIL rand_count: got %0d want 50", got); end
    nApplied++;
    if (hvCnt !== 26'd50) begin nMiss++; $display("[TB] FAIL rand_hv_cnt: got %0d want 50", hvCnt); end
  endtask

  initial begin
    rst     = 1'b1;
    flush   = 1'b0;
    srcV    = 1'b0;
    srcD    = 32'h0;
    hvReady = 1'b0;
    step();
    test_reset();
    test_assembly_order();
    test_double_buffer();
    test_back_to_back();
    test_flush();
    test_reset_midvector();
    test_random_scoreboard();
    $display("== %0d vectors applied, %0d miscompares ==", nApplied, nMiss);
    $finish;
  end

endmodule
